// File: rtl/adpll_coarse_ctrl.sv
// Coarse DCO code controller: counts CLK cycles per REF period, binary-searches the code MSB-first, then tracks +/-1 and flags lock.
// Latency: COARSE/STATE/LOCK/MEAS update on the CLK edge that consumes the ref_rise pulse (3 CLK after a REF rising edge).
// No backpressure: free-running closed loop; ENABLE low forces IDLE on the next edge.
module adpll_coarse_ctrl #(
   parameter int CODE_W   = 7,
   parameter int CNT_W    = 10,
   parameter int TOL      = 1,
   parameter int SETTLE   = 2,
   parameter int LOCK_CNT = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              ref_in_i,
   input  logic              enable_i,
   input  logic [CNT_W-1:0]  fcw_i,
   output logic [CODE_W-1:0] coarse_o,
   output logic              lock_o,
   output logic [1:0]        state_o,
   output logic [CNT_W-1:0]  meas_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, TRACK = 2'd2} state_e;

   localparam int KW = $clog2(CODE_W);
   localparam int SW = $clog2(SETTLE + 2);
   localparam int LW = $clog2(LOCK_CNT + 2);
   localparam int EW = CNT_W + 1;
   localparam logic [CODE_W-1:0] MID      = {1'b1, {(CODE_W-1){1'b0}}};
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [SW-1:0]     SETTLE_V = SW'(SETTLE);
   localparam logic [LW-1:0]     LOCK_MAX = LW'(LOCK_CNT);
   localparam logic [EW-1:0]     TOL_V    = EW'(TOL);

   logic              ref_s1_q, ref_s2_q, ref_s3_q;
   logic [CNT_W-1:0]  cnt_q, meas_q;
   state_e            state_q, state_d;
   logic [CODE_W-1:0] coarse_q, coarse_d;
   logic [KW-1:0]     k_q, k_d;
   logic [SW-1:0]     settle_q, settle_d;
   logic [LW-1:0]     lock_cnt_q, lock_cnt_d, lock_inc;
   logic              lock_q, lock_d;
   logic              first_q, first_d;
   logic              ref_rise, meas_vld, meas_used;
   logic [EW-1:0]     meas_ext, fcw_ext;

   assign ref_rise  = ref_s2_q & ~ref_s3_q;
   assign meas_vld  = ref_rise & ~first_q;
   assign meas_used = meas_vld & (settle_q == '0);
   // The fresh count is judged on the same edge it lands in MEAS.
   assign meas_ext  = {1'b0, cnt_q};
   assign fcw_ext   = {1'b0, fcw_i};
   assign lock_inc  = lock_cnt_q + LW'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ref_s1_q <= 1'b0;
         ref_s2_q <= 1'b0;
         ref_s3_q <= 1'b0;
         cnt_q    <= '0;
         meas_q   <= '0;
      end else begin
         ref_s1_q <= ref_in_i;
         ref_s2_q <= ref_s1_q;
         ref_s3_q <= ref_s2_q;
         if (ref_rise) begin
            meas_q <= cnt_q;
            cnt_q  <= CNT_W'(1);
         end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      coarse_d   = coarse_q;
      k_d        = k_q;
      settle_d   = settle_q;
      lock_cnt_d = lock_cnt_q;
      lock_d     = lock_q;
      first_d    = ref_rise ? 1'b0 : first_q;
      case (state_q)
         IDLE: begin
            coarse_d   = MID;
            lock_d     = 1'b0;
            lock_cnt_d = '0;
            first_d    = 1'b1;
            if (enable_i) begin
               state_d  = SEARCH;
               k_d      = KW'(CODE_W - 1);
               settle_d = SETTLE_V;
            end
         end
         SEARCH: begin
            if (meas_used) begin
               if (meas_ext >= fcw_ext) coarse_d[k_q] = 1'b0;
               if (k_q != '0) begin
                  coarse_d[k_q - KW'(1)] = 1'b1;
                  k_d = k_q - KW'(1);
               end else begin
                  state_d = TRACK;
               end
            end
         end
         TRACK: begin
            if (meas_used) begin
               if (meas_ext + TOL_V < fcw_ext) begin
                  if (coarse_q != '1) coarse_d = coarse_q + CODE_W'(1);
                  lock_cnt_d = '0;
                  lock_d     = 1'b0;
               end else if (meas_ext > fcw_ext + TOL_V) begin
                  if (coarse_q != '0) coarse_d = coarse_q - CODE_W'(1);
                  lock_cnt_d = '0;
                  lock_d     = 1'b0;
               end else begin
                  if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_inc;
                  if (lock_inc >= LOCK_MAX) lock_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Any real code step restarts the settle window; a saturated no-op step does not.
      if (state_q != IDLE) begin
         if (coarse_d != coarse_q) settle_d = SETTLE_V;
         else if (meas_vld && settle_q != '0) settle_d = settle_q - SW'(1);
      end
      if (!enable_i) begin
         state_d    = IDLE;
         coarse_d   = MID;
         lock_d     = 1'b0;
         lock_cnt_d = '0;
         first_d    = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         coarse_q   <= MID;
         k_q        <= '0;
         settle_q   <= '0;
         lock_cnt_q <= '0;
         lock_q     <= 1'b0;
         first_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         coarse_q   <= coarse_d;
         k_q        <= k_d;
         settle_q   <= settle_d;
         lock_cnt_q <= lock_cnt_d;
         lock_q     <= lock_d;
         first_q    <= first_d;
      end
   end

   assign coarse_o = coarse_q;
   assign lock_o   = lock_q;
   assign state_o  = state_q;
   assign meas_o   = meas_q;

endmodule

// File: tb/tb_adpll_coarse_ctrl.sv
// Bench for adpll_coarse_ctrl: directed REF periods on a fixed CLK, then a closed loop with a DCO period model.
// Expected outputs are queued at each checkpoint and compared by an independent monitor on the falling CLK edge.
module tb_adpll_coarse_ctrl;

   logic       clk, rst_n, ref_in, enable;
   logic [9:0] fcw;
   logic [6:0] coarse;
   logic       lock;
   logic [1:0] state;
   logic [9:0] meas;

   int total = 0;
   int bad   = 0;
   bit dco_mode = 1'b0;
   int ref_hi = 250;
   int ref_lo = 250;

   typedef struct {
      string name;
      int    c_lo, c_hi, st, lk, m_lo, m_hi;
   } exp_t;
   exp_t sb_q[$];

   adpll_coarse_ctrl dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .ref_in_i (ref_in),
      .enable_i (enable),
      .fcw_i    (fcw),
      .coarse_o (coarse),
      .lock_o   (lock),
      .state_o  (state),
      .meas_o   (meas)
   );

   // Fixed CLK period 10; DCO mode period = 6400/(code+36), i.e. 100 at code 28.
   initial begin
      clk = 1'b0;
      forever begin
         int per;
         per = dco_mode ? 6400 / (int'(coarse) + 36) : 10;
         #(per / 2) clk = 1'b1;
         #(per - per / 2) clk = 1'b0;
      end
   end

   initial begin
      ref_in = 1'b0;
      #2;
      forever begin
         ref_in = 1'b1;
         #(ref_hi);
         ref_in = 1'b0;
         #(ref_lo);
      end
   end

   task automatic chk(input string nm, input string fld, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s.%s: got %0d, expected %0d..%0d", nm, fld, act, lo, hi);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.name, "coarse", int'(coarse), e.c_lo, e.c_hi);
            chk(e.name, "state",  int'(state),  e.st,   e.st);
            chk(e.name, "lock",   int'(lock),   e.lk,   e.lk);
            chk(e.name, "meas",   int'(meas),   e.m_lo, e.m_hi);
         end
      end
   end

   task automatic expect_now(input string nm, input int c_lo, input int c_hi, input int st,
                             input int lk, input int m_lo, input int m_hi);
      exp_t e;
      e.name = nm; e.c_lo = c_lo; e.c_hi = c_hi; e.st = st;
      e.lk = lk; e.m_lo = m_lo; e.m_hi = m_hi;
      sb_q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic set_ref(input int hi, input int lo);
      ref_hi = hi;
      ref_lo = lo;
   endtask

   task automatic wait_refs(input int n);
      repeat (n) @(posedge ref_in);
      repeat (5) @(posedge clk);
   endtask

   task automatic start_loop();
      @(posedge ref_in);
      repeat (5) @(posedge clk);
      #1 enable = 1'b1;
   endtask

   task automatic stop_loop();
      @(posedge clk);
      #1 enable = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached with %0d checks queued", sb_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      fcw    = 10'd40;
      set_ref(250, 250);
      repeat (3) @(posedge clk);
      expect_now("reset", 64, 64, 0, 0, 0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // REF = 50 CLK: every decision clears, one decision per 3 REF periods after the partial one.
      start_loop();
      wait_refs(4);  expect_now("p50_d1",  32, 32, 1, 0, 50, 50);
      wait_refs(17); expect_now("p50_d6",   1,  1, 1, 0, 50, 50);
      wait_refs(1);  expect_now("p50_end",  0,  0, 2, 0, 50, 50);
      wait_refs(4);  expect_now("p50_sat",  0,  0, 2, 0, 50, 50);

      // Asynchronous reset mid-TRACK, seen before the next rising CLK edge.
      @(posedge clk);
      #2 rst_n = 1'b0;
      expect_now("async_rst", 64, 64, 0, 0, 0, 0);
      enable = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // REF = 30 CLK: every decision keeps, TRACK saturates at the top.
      set_ref(150, 150);
      start_loop();
      wait_refs(4);  expect_now("p30_d1",  96,  96, 1, 0, 30, 30);
      wait_refs(18); expect_now("p30_end", 127, 127, 2, 0, 30, 30);
      wait_refs(4);  expect_now("p30_sat", 127, 127, 2, 0, 30, 30);
      stop_loop();   expect_now("dis_track", 64, 64, 0, 0, 30, 30);

      // REF = 40 CLK: in-band tracking, lock on the 4th used measurement, then REF moves to 45.
      set_ref(200, 200);
      start_loop();
      wait_refs(22); expect_now("p40_end",  0, 0, 2, 0, 40, 40);
      wait_refs(5);  expect_now("p40_pre",  0, 0, 2, 0, 40, 40);
      wait_refs(1);  expect_now("p40_lock", 0, 0, 2, 1, 40, 40);
      set_ref(225, 225);
      wait_refs(1);  expect_now("p45_drop", 0, 0, 2, 0, 42, 45);
      stop_loop();

      // Disable during SEARCH with k=3, then restart from the MSB.
      set_ref(250, 250);
      start_loop();
      wait_refs(10); expect_now("p50_k3", 8, 8, 1, 0, 50, 50);
      wait_refs(1);
      stop_loop();   expect_now("dis_search", 64, 64, 0, 0, 50, 50);
      start_loop();
      wait_refs(3);  expect_now("re_settle", 64, 64, 1, 0, 50, 50);
      wait_refs(1);  expect_now("re_d1",     32, 32, 1, 0, 50, 50);
      stop_loop();

      // Closed loop: DCO period follows COARSE, REF period 4000, FCW 40.
      repeat (3) @(posedge clk);
      dco_mode = 1'b1;
      set_ref(2000, 2000);
      start_loop();
      for (int i = 0; i < 150 && !lock; i++) wait_refs(1);
      expect_now("dco_lock", 26, 30, 2, 1, 39, 41);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
